// File: rtl/dff16_chain_unloader.sv
// dff16_chain_unloader: captures a DEPTH-word frame in one handshake and streams it
// highest word first, so a downstream shift chain ends with stage k holding word k.
module dff16_chain_unloader #(
  parameter int DW    = 16,
  parameter int DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DW*DEPTH-1:0]   din_flat,
  output logic [DW-1:0]         dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  busy,
  output logic                  done
);
  localparam int IW = $clog2(DEPTH);
  typedef enum logic {IDLE, SEND} state_t;
  state_t        r_state, w_state_nxt;
  logic [DW-1:0] r_buf [DEPTH];
  logic [IW-1:0] r_idx, w_idx_dn;
  logic [DW-1:0] r_dout;
  logic          r_dout_valid, r_done;
  logic          w_load, w_xfer, w_last;
  assign w_load   = (r_state == IDLE) & load_valid;
  assign w_xfer   = r_dout_valid & dout_ready;
  assign w_last   = w_xfer & (r_idx == '0);
  assign w_idx_dn = r_idx - 1'b1;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign done       = r_done;
  always_comb begin
    w_state_nxt = r_state;
    load_ready  = (r_state == IDLE);
    busy        = (r_state == SEND);
    if (w_load) w_state_nxt = SEND;
    else if (w_last) w_state_nxt = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_state_nxt;
  // dout_valid is high only in SEND, so a load and a transfer never coincide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) r_buf[k] <= '0;
      r_idx        <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_load) begin
        for (int k = 0; k < DEPTH; k++) r_buf[k] <= din_flat[k*DW +: DW];
        r_idx        <= IW'(DEPTH - 1);
        r_dout       <= din_flat[(DEPTH-1)*DW +: DW];
        r_dout_valid <= 1'b1;
      end else if (w_last) begin
        r_dout       <= '0;
        r_dout_valid <= 1'b0;
      end else if (w_xfer) begin
        r_idx  <= w_idx_dn;
        r_dout <= r_buf[w_idx_dn];
      end
    end
  end
endmodule

// File: tb/tb_dff16_chain_unloader.sv
// tb_dff16_chain_unloader: scoreboard bench; stimulus queues expected words, a negedge
// monitor pops them on each transfer and models the receiving 16-stage shift chain.
module tb_dff16_chain_unloader;
  localparam int DW = 16, DEPTH = 16;
  logic clk = 0, rst = 0, load_valid = 0, dout_ready = 0;
  logic [DW*DEPTH-1:0] din_flat = '0;
  logic load_ready, dout_valid, busy, done;
  logic [DW-1:0] dout;
  typedef struct packed {logic [DW-1:0] w; logic last;} exp_t;
  exp_t q[$];
  exp_t e;
  logic [DW-1:0] chain [DEPTH];
  logic exp_done = 0;
  int total = 0, bad = 0;
  int n, m, m2;

  always #5 clk = ~clk;

  dff16_chain_unloader #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .din_flat(din_flat), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .busy(busy), .done(done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    check("done_pulse", done, exp_done);
    exp_done = 0;
    if (!rst && dout_valid && dout_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got %0h want none at %0t", dout, $time);
      end else begin
        e = q.pop_front();
        check("dout_word", dout, e.w);
        exp_done = e.last;
      end
      for (int k = DEPTH - 1; k > 0; k--) chain[k] = chain[k-1];
      chain[0] = dout;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [DW-1:0] base);
    check("load_ready_before_load", load_ready, 1);
    for (int k = 0; k < DEPTH; k++) din_flat[k*DW +: DW] = base + DW'(k);
    load_valid = 1;
    for (int k = DEPTH - 1; k >= 0; k--) q.push_back(exp_t'{w: base + DW'(k), last: (k == 0)});
    tick;
    load_valid = 0;
  endtask

  task automatic wait_done(input int budget, output int cnt);
    cnt = 0;
    while (!done && cnt < budget) begin
      tick;
      cnt++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL wait_done: got timeout after %0d cycles want done", cnt);
    end
  endtask

  task automatic clear_chain;
    for (int k = 0; k < DEPTH; k++) chain[k] = '0;
  endtask

  task automatic check_chain(input logic [DW-1:0] base);
    for (int k = 0; k < DEPTH; k++)
      check($sformatf("chain_stage%0d", k), chain[k], base + DW'(k));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_dout"}, dout, 0);
    check({tag, "_dout_valid"}, dout_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_load_ready"}, load_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    // reset with random inputs
    #1;
    rst = 1;
    load_valid = 1'($urandom);
    dout_ready = 1'($urandom);
    din_flat = {8{$urandom}};
    #1;
    check_idle("rst_async");
    check("rst_async_done", done, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check_idle("rst_hold");
      check("rst_hold_done", done, 0);
    end
    load_valid = 0;
    dout_ready = 0;
    rst = 0;
    repeat (2) tick;
    check_idle("post_rst");

    // basic frame, always ready
    dout_ready = 1;
    clear_chain();
    load(16'h1100);
    check("basic_first_valid", dout_valid, 1);
    check("basic_first_word", dout, 16'h110F);
    check("basic_busy", busy, 1);
    check("basic_load_ready", load_ready, 0);
    wait_done(40, n);
    check("basic_cycles", n, 16);
    check("basic_done_load_ready", load_ready, 1);
    check("basic_done_valid", dout_valid, 0);
    check_chain(16'h1100);
    tick;
    check_idle("basic_after");
    check("basic_after_done", done, 0);

    // backpressure at idx 9 with an ignored load mid-frame
    load(16'h1100);
    n = 0;
    while (dout !== 16'h1109 && n < 20) begin
      tick;
      n++;
    end
    check("bp_reach_1109", dout, 16'h1109);
    dout_ready = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        load_valid = 1;
        din_flat = '1;
      end
      check("bp_stall_word", dout, 16'h1109);
      check("bp_stall_valid", dout_valid, 1);
      check("bp_stall_load_ready", load_ready, 0);
      tick;
      load_valid = 0;
    end
    dout_ready = 1;
    n = 0;
    while (!done && n < 60) begin
      check("bp_load_ready_low", load_ready, 0);
      tick;
      dout_ready = ~dout_ready;
      n++;
    end
    check("bp_done_seen", done, 1);
    check("bp_queue_drained", q.size(), 0);
    check("bp_done_load_ready", load_ready, 1);

    // back-to-back frames, second load in the done cycle
    dout_ready = 1;
    repeat (2) tick;
    load(16'h1100);
    wait_done(40, m);
    load(16'h2200);
    check("b2b_second_first", dout, 16'h220F);
    wait_done(40, m2);
    check("b2b_total_cycles", 1 + m + 1 + m2, 34);

    // reset mid-frame after 7 transfers
    tick;
    load(16'h1100);
    repeat (7) tick;
    rst = 1;
    #1;
    check_idle("midrst");
    check("midrst_done", done, 0);
    q.delete();
    tick;
    check("midrst_hold_done", done, 0);
    rst = 0;
    tick;
    check_idle("midrst_after");
    clear_chain();
    load(16'h3300);
    check("midrst_next_first", dout, 16'h330F);
    wait_done(40, n);
    check("midrst_next_cycles", n, 16);
    check_chain(16'h3300);
    tick;
    check("final_queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dff16_chain_unloader.md
Name: dff16_chain_unloader

Overview:
- Parallel-in/serial-out counterpart of the team's 16-deep, 16-bit shift chain.
- Captures a frame of DEPTH parallel words in one handshake, then streams them one word per accepted beat on a valid/ready output.
- The emission order is fixed so that a downstream shift chain, shifting once per beat, ends with chain stage k holding input word k.
- Sits between a frame-producing block and a serial link that feeds a receiving chain.

Parameters:
- DW, 16, word width in bits.
- DEPTH, 16, words per frame; must be ≥2. Counter width is clog2(DEPTH).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- load_valid  input  1  upstream asserts when din_flat holds a complete frame.
- load_ready  output  1  block can accept a frame; combinational, equals (state==IDLE).
- din_flat  input  DW*DEPTH  frame; word k = din_flat[k*DW +: DW], k=0..DEPTH-1.
- dout  output  DW  current serial word, registered.
- dout_valid  output  1  dout holds a valid word, registered.
- dout_ready  input  1  downstream accepts dout this cycle.
- busy  output  1  high in SEND; equals (state==SEND).
- done  output  1  one-cycle registered pulse after the last word of a frame transfers.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; frame buffer all 0; idx=0; dout=0; dout_valid=0; done=0.
  - load_ready reads 1 and busy reads 0 while in reset, because both follow state.
- Load (IDLE, load_valid=1):
  - Capture all DEPTH words into the buffer; idx<=DEPTH-1; state<=SEND.
  - dout<=word[DEPTH-1]; dout_valid<=1.
  - The first word is valid the cycle after load is accepted (latency 1).
- load_valid in SEND is ignored (load_ready=0). The buffer is never overwritten mid-frame.
- Transfer = dout_valid & dout_ready at a rising edge.
- On a transfer with idx>0: idx<=idx-1; dout<=word[idx-1]; dout_valid stays 1.
- On a transfer with idx==0 (last word):
  - state<=IDLE; dout_valid<=0; dout<=0; done<=1 for exactly one cycle.
- Emission order is word[DEPTH-1], word[DEPTH-2], …, word[0]. Exactly DEPTH transfers per frame, no gaps inserted by the block.
- Backpressure: while dout_valid=1 and dout_ready=0, dout, dout_valid and idx hold unchanged. The stall length is unbounded.
- done is 0 in every cycle except the one after the last transfer. done=1 coincides with the first IDLE cycle, so load_ready=1 in that same cycle.
- Minimum frame period is DEPTH+1 cycles: load cycle plus DEPTH transfer cycles. A new load can be accepted in the cycle done=1.
- dout_ready is don't-care when dout_valid=0.
- Reset mid-frame: all state clears immediately. The partial frame is discarded, with no done pulse. After release, the block waits in IDLE for a new load.
- No arithmetic beyond the idx decrement. idx never wraps, because SEND exits at idx==0.

Test Plan:
- Reset values: assert rst with random inputs → dout=0, dout_valid=0, done=0, busy=0, load_ready=1. Hold for 3 cycles, release, stay idle.
- Basic frame: load word k=16'h1100+k, dout_ready=1 always → dout_valid rises 1 cycle after load. dout sequence is 0x110F, 0x110E, …, 0x1100 on 16 consecutive cycles. done pulses once after 0x1100, then dout_valid=0.
- Backpressure: same frame, dout_ready low for 5 cycles at idx=9 and toggled every cycle afterwards → no word is lost or duplicated. dout holds 0x1109 throughout the stall, and the 16 words arrive in order.
- Load ignored while busy: mid-frame, pulse load_valid with a frame of all 16'hFFFF → original words continue unchanged, and load_ready stays 0 until done.
- Back-to-back frames: assert load_valid in the done cycle with a second frame (k=16'h2200+k) → the second frame starts with 0x220F the next cycle. Total is 34 cycles for two frames with dout_ready=1.
- Round trip and reset mid-frame: feed dout/dout_valid&dout_ready into the 16-stage chain's din/data_valid → after 16 transfers, chain stage k equals 16'h1100+k. A separate run asserts rst after 7 transfers → outputs clear immediately, no done pulse, and the next frame streams correctly.
